// File: rtl/dcu_pkg.sv
// Shared definitions for the decode-stage dependency check unit.
// Holds opcode constants, forwarding-select encodings and the history entry type.
// Contains no logic apart from a small opcode canonicalisation helper.
package dcu_pkg;

  localparam int DCU_REG_AW = 5;

  // ALU register ops
  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_AND  = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b000011;
  localparam logic [5:0] OP_XOR  = 6'b000100;
  // Immediate ops (opcode[5] set)
  localparam logic [5:0] OP_ADDI = 6'b100000;
  localparam logic [5:0] OP_SUBI = 6'b100001;
  localparam logic [5:0] OP_LD   = 6'b101100;
  localparam logic [5:0] OP_ST   = 6'b101101;
  localparam logic [5:0] OP_NOP  = 6'b111111;

  // Operand source selects seen by the EX-stage operand muxes
  typedef enum logic [1:0] {
    SEL_RF = 2'b00,
    SEL_EX = 2'b01,
    SEL_DM = 2'b10,
    SEL_WB = 2'b11
  } sel_e;

  // One in-flight instruction as far as hazard tracking is concerned
  typedef struct packed {
    logic                  valid;
    logic [DCU_REG_AW-1:0] rw;
    logic                  is_load;
  } hist_entry_t;

  localparam hist_entry_t HIST_BUBBLE = '0;

  // Any opcode outside the supported set behaves exactly like NOP
  function automatic logic [5:0] canon_op(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_ADDI, OP_SUBI, OP_LD, OP_ST: canon_op = op;
      default:                        canon_op = OP_NOP;
    endcase
  endfunction

endpackage

// File: rtl/dependency_check_unit_fwd_select.sv
// Forwarding source select for one operand: nearest older writer of i_src wins.
// Ports: i_src (source register), i_ex/i_dm/i_wb (history slots), o_sel (2-bit select).
// Purely combinational; register 0 never forwards.
module fwd_select
  import dcu_pkg::*;
(
  input  logic [DCU_REG_AW-1:0] i_src,
  input  hist_entry_t           i_ex,
  input  hist_entry_t           i_dm,
  input  hist_entry_t           i_wb,
  output sel_e                  o_sel
);

  always_comb begin
    o_sel = SEL_RF;
    if (i_src != '0) begin
      if (i_ex.valid && (i_ex.rw == i_src)) begin
        o_sel = SEL_EX;
      end else if (i_dm.valid && (i_dm.rw == i_src)) begin
        o_sel = SEL_DM;
      end else if (i_wb.valid && (i_wb.rw == i_src)) begin
        o_sel = SEL_WB;
      end
    end
  end

endmodule

// File: rtl/dependency_check_unit.sv
// Decode-stage hazard/forwarding controller driving the register-bank control inputs.
// Ports: clk, rst_n, ins/ins_valid in; RA, RB, RW_dm, imm, imm_sel, mux_sel_A/B, alu_op
// registered (1 cycle after ins sampled, RW_dm from DM history); stall combinational.
module dependency_check_unit
  import dcu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_AW = 5,
  parameter int INS_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [INS_W-1:0]  ins,
  input  logic              ins_valid,
  output logic [REG_AW-1:0] RA,
  output logic [REG_AW-1:0] RB,
  output logic [REG_AW-1:0] RW_dm,
  output logic [DATA_W-1:0] imm,
  output logic              imm_sel,
  output logic [1:0]        mux_sel_A,
  output logic [1:0]        mux_sel_B,
  output logic [5:0]        alu_op,
  output logic              stall
);

  // Instruction fields
  logic [5:0]        w_opcode;
  logic [REG_AW-1:0] w_rw;
  logic [REG_AW-1:0] w_ra;
  logic [REG_AW-1:0] w_rb;
  logic [DATA_W-1:0] w_imm;

  assign w_opcode = ins[31:26];
  assign w_rw     = ins[25:21];
  assign w_ra     = ins[20:16];
  assign w_rb     = ins[15:11];
  assign w_imm    = ins[DATA_W-1:0];

  // Decode
  logic [5:0] w_op;
  logic       w_live;      // real instruction that reads operands
  logic       w_imm_sel;
  logic       w_writes;
  logic       w_is_load;

  assign w_op      = canon_op(w_opcode);
  assign w_live    = ins_valid && (w_op != OP_NOP);
  assign w_imm_sel = w_live && w_op[5];
  assign w_writes  = w_live && (w_op != OP_ST) && (w_rw != '0);
  assign w_is_load = (w_op == OP_LD);

  // History: the three older in-flight instructions
  hist_entry_t r_hist_ex;
  hist_entry_t r_hist_dm;
  hist_entry_t r_hist_wb;

  // Forwarding selects against the pre-update history
  sel_e w_sel_a;
  sel_e w_sel_b;

  fwd_select u_fwd_a (
    .i_src (w_ra),
    .i_ex  (r_hist_ex),
    .i_dm  (r_hist_dm),
    .i_wb  (r_hist_wb),
    .o_sel (w_sel_a)
  );

  fwd_select u_fwd_b (
    .i_src (w_rb),
    .i_ex  (r_hist_ex),
    .i_dm  (r_hist_dm),
    .i_wb  (r_hist_wb),
    .o_sel (w_sel_b)
  );

  // Load-use: a load result is not available in EX, so the consumer waits one
  // cycle and then picks it up from DM. B only counts when it reads a register.
  logic w_hz_a;
  logic w_hz_b;
  logic w_stall;
  logic w_issue;

  assign w_hz_a  = (w_ra != '0) && (w_ra == r_hist_ex.rw);
  assign w_hz_b  = !w_imm_sel && (w_rb != '0) && (w_rb == r_hist_ex.rw);
  assign w_stall = w_live && r_hist_ex.valid && r_hist_ex.is_load && (w_hz_a || w_hz_b);
  assign w_issue = ins_valid && !w_stall;

  hist_entry_t w_new_entry;

  always_comb begin
    w_new_entry = HIST_BUBBLE;
    if (w_issue && w_writes) begin
      w_new_entry.valid   = 1'b1;
      w_new_entry.rw      = w_rw;
      w_new_entry.is_load = w_is_load;
    end
  end

  // Registered control outputs
  logic [REG_AW-1:0] r_ra;
  logic [REG_AW-1:0] r_rb;
  logic [DATA_W-1:0] r_imm;
  logic              r_imm_sel;
  logic [5:0]        r_alu_op;
  sel_e              r_sel_a;
  sel_e              r_sel_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist_ex <= HIST_BUBBLE;
      r_hist_dm <= HIST_BUBBLE;
      r_hist_wb <= HIST_BUBBLE;
      r_ra      <= '0;
      r_rb      <= '0;
      r_imm     <= '0;
      r_imm_sel <= 1'b0;
      r_alu_op  <= '0;
      r_sel_a   <= SEL_RF;
      r_sel_b   <= SEL_RF;
    end else begin
      r_hist_wb <= r_hist_dm;
      r_hist_dm <= r_hist_ex;
      r_hist_ex <= w_new_entry;
      if (w_issue) begin
        r_ra      <= w_ra;
        r_rb      <= w_rb;
        r_imm     <= w_imm;
        r_imm_sel <= w_imm_sel;
        r_alu_op  <= w_op;
        r_sel_a   <= w_live ? w_sel_a : SEL_RF;
        r_sel_b   <= (w_live && !w_imm_sel) ? w_sel_b : SEL_RF;
      end else begin
        // Bubble into EX: nothing reads or writes
        r_ra      <= '0;
        r_rb      <= '0;
        r_imm     <= '0;
        r_imm_sel <= 1'b0;
        r_alu_op  <= OP_NOP;
        r_sel_a   <= SEL_RF;
        r_sel_b   <= SEL_RF;
      end
    end
  end

  assign RA        = r_ra;
  assign RB        = r_rb;
  assign imm       = r_imm;
  assign imm_sel   = r_imm_sel;
  assign alu_op    = r_alu_op;
  assign mux_sel_A = r_sel_a;
  assign mux_sel_B = r_sel_b;
  assign RW_dm     = r_hist_dm.valid ? r_hist_dm.rw : '0;
  assign stall     = w_stall;

endmodule

// File: tb/tb_dependency_check_unit.sv
module tb_dependency_check_unit;

  localparam logic [5:0] T_ADD  = 6'b000000;
  localparam logic [5:0] T_SUB  = 6'b000001;
  localparam logic [5:0] T_ADDI = 6'b100000;
  localparam logic [5:0] T_SUBI = 6'b100001;
  localparam logic [5:0] T_LD   = 6'b101100;
  localparam logic [5:0] T_ST   = 6'b101101;
  localparam logic [5:0] T_NOP  = 6'b111111;
  localparam logic [31:0] NOP_INS = 32'hFC00_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ins;
  logic        ins_valid;
  logic [4:0]  RA, RB, RW_dm;
  logic [15:0] imm;
  logic        imm_sel;
  logic [1:0]  mux_sel_A, mux_sel_B;
  logic [5:0]  alu_op;
  logic        stall;

  int n_cmp = 0;
  int n_err = 0;

  dependency_check_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ins       (ins),
    .ins_valid (ins_valid),
    .RA        (RA),
    .RB        (RB),
    .RW_dm     (RW_dm),
    .imm       (imm),
    .imm_sel   (imm_sel),
    .mux_sel_A (mux_sel_A),
    .mux_sel_B (mux_sel_B),
    .alu_op    (alu_op),
    .stall     (stall)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // Reference model: list of the most recently issued instructions, newest first
  typedef struct packed {
    logic       v;
    logic [4:0] rw;
    logic       ld;
  } rec_t;
  rec_t mq[$];

  function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rw,
                                        input logic [4:0] ra, input logic [4:0] rb);
    return {op, rw, ra, rb, 11'd0};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rw,
                                        input logic [4:0] ra, input logic [15:0] iv);
    return {op, rw, ra, iv};
  endfunction

  // Distance to the nearest older writer of src (1..3), 0 if none
  function automatic logic [1:0] model_sel(input logic [4:0] src, input logic use_src);
    if (!use_src || src == 5'd0) return 2'd0;
    for (int i = 0; i < 3; i++) begin
      if (mq[i].v && mq[i].rw == src) return 2'(i + 1);
    end
    return 2'd0;
  endfunction

  function automatic logic [31:0] rand_ins();
    logic [5:0] ops [12];
    logic [5:0] op;
    ops = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h20, 6'h21, 6'h2C, 6'h2D, 6'h3F, 6'h2C, 6'h2C};
    op = ops[$urandom_range(11)];
    if (op == T_NOP) return NOP_INS;
    return {op, 5'($urandom_range(7)), 5'($urandom_range(7)), 5'($urandom_range(7)),
            11'($urandom)};
  endfunction

  task automatic cyc(input logic [31:0] i, input logic v);
    ins = i;
    ins_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    repeat (3) cyc(32'd0, 1'b0);
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if ({RA, RB, RW_dm, imm, imm_sel, mux_sel_A, mux_sel_B, alu_op, stall} !== 43'd0) begin
      n_err++;
      $display("FAIL reset_initial: got %h required 0",
               {RA, RB, RW_dm, imm, imm_sel, mux_sel_A, mux_sel_B, alu_op, stall});
    end
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(enc_i(T_LD, 5'd7, 5'd1, 16'h1234), 1'b1);
    cyc(enc_r(T_ADD, 5'd9, 5'd7, 5'd3), 1'b1);  // stalls on R7
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({RA, RB, RW_dm, imm, imm_sel, mux_sel_A, mux_sel_B, alu_op, stall} !== 43'd0) begin
      n_err++;
      $display("FAIL reset_async: got %h required 0",
               {RA, RB, RW_dm, imm, imm_sel, mux_sel_A, mux_sel_B, alu_op, stall});
    end
    ins_valid = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(enc_r(T_ADD, 5'd3, 5'd1, 5'd2), 1'b1);
    n_cmp++;
    if ({mux_sel_A, mux_sel_B} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_first_add_sel: got %b required 0000", {mux_sel_A, mux_sel_B});
    end
    n_cmp++;
    if ({RA, RB, alu_op} !== {5'd1, 5'd2, T_ADD}) begin
      n_err++;
      $display("FAIL reset_first_add_fields: got %h required %h", {RA, RB, alu_op},
               {5'd1, 5'd2, T_ADD});
    end
  endtask

  task automatic test_back_to_back();
    flush();
    cyc(enc_r(T_ADD, 5'd7, 5'd1, 5'd2), 1'b1);
    cyc(enc_r(T_SUB, 5'd8, 5'd7, 5'd7), 1'b1);
    n_cmp++;
    if ({mux_sel_A, mux_sel_B} !== 4'b0101) begin
      n_err++;
      $display("FAIL b2b_sel: got %b required 0101", {mux_sel_A, mux_sel_B});
    end
  endtask

  task automatic test_distance();
    for (int gap = 1; gap <= 3; gap++) begin
      logic [1:0] exp_a;
      exp_a = (gap == 3) ? 2'b00 : 2'(gap + 1);
      flush();
      cyc(enc_r(T_ADD, 5'd7, 5'd1, 5'd2), 1'b1);
      for (int k = 0; k < gap; k++) begin
        cyc(NOP_INS, 1'b1);
        if (k == 0) begin
          n_cmp++;
          if (RW_dm !== 5'd7) begin
            n_err++;
            $display("FAIL dist_rw_dm: got %0d required 7", RW_dm);
          end
        end
      end
      cyc(enc_r(T_ADD, 5'd9, 5'd7, 5'd2), 1'b1);
      n_cmp++;
      if ({mux_sel_A, mux_sel_B} !== {exp_a, 2'b00}) begin
        n_err++;
        $display("FAIL dist%0d_sel: got %b required %b", gap + 1, {mux_sel_A, mux_sel_B},
                 {exp_a, 2'b00});
      end
    end
  endtask

  task automatic test_imm_r0();
    flush();
    cyc(enc_r(T_ADD, 5'd0, 5'd1, 5'd2), 1'b1);
    cyc(enc_i(T_ADDI, 5'd5, 5'd0, 16'hFFFF), 1'b1);
    n_cmp++;
    if ({imm, imm_sel, alu_op} !== {16'hFFFF, 1'b1, T_ADDI}) begin
      n_err++;
      $display("FAIL imm_fields: got %h required %h", {imm, imm_sel, alu_op},
               {16'hFFFF, 1'b1, T_ADDI});
    end
    n_cmp++;
    if ({mux_sel_A, mux_sel_B} !== 4'b0000) begin
      n_err++;
      $display("FAIL imm_r0_sel: got %b required 0000", {mux_sel_A, mux_sel_B});
    end
  endtask

  task automatic test_load_use();
    flush();
    cyc(enc_i(T_LD, 5'd6, 5'd1, 16'd4), 1'b1);
    ins = enc_r(T_ADD, 5'd4, 5'd6, 5'd2);
    ins_valid = 1'b1;
    #2;
    n_cmp++;
    if (stall !== 1'b1) begin
      n_err++;
      $display("FAIL ld_use_stall: got %b required 1", stall);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({alu_op, imm_sel, mux_sel_A, mux_sel_B} !== {T_NOP, 1'b0, 4'b0000}) begin
      n_err++;
      $display("FAIL ld_use_bubble: got %h required %h", {alu_op, imm_sel, mux_sel_A, mux_sel_B},
               {T_NOP, 1'b0, 4'b0000});
    end
    #2;
    n_cmp++;
    if (stall !== 1'b0) begin
      n_err++;
      $display("FAIL ld_use_stall_fall: got %b required 0", stall);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({RA, alu_op, mux_sel_A, mux_sel_B} !== {5'd6, T_ADD, 2'b10, 2'b00}) begin
      n_err++;
      $display("FAIL ld_use_redecode: got %h required %h", {RA, alu_op, mux_sel_A, mux_sel_B},
               {5'd6, T_ADD, 2'b10, 2'b00});
    end
  endtask

  task automatic test_priority();
    flush();
    cyc(enc_r(T_ADD, 5'd7, 5'd1, 5'd2), 1'b1);
    cyc(enc_r(T_ADD, 5'd7, 5'd3, 5'd4), 1'b1);
    cyc(enc_r(T_ADD, 5'd3, 5'd7, 5'd7), 1'b1);
    n_cmp++;
    if ({mux_sel_A, mux_sel_B} !== 4'b0101) begin
      n_err++;
      $display("FAIL priority_sel: got %b required 0101", {mux_sel_A, mux_sel_B});
    end
  endtask

  task automatic test_reset_mid_stall();
    flush();
    cyc(enc_i(T_LD, 5'd6, 5'd1, 16'd8), 1'b1);
    ins = enc_r(T_ADD, 5'd4, 5'd6, 5'd6);
    ins_valid = 1'b1;
    #2;
    n_cmp++;
    if (stall !== 1'b1) begin
      n_err++;
      $display("FAIL mid_stall_pre: got %b required 1", stall);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({stall, RW_dm} !== 6'd0) begin
      n_err++;
      $display("FAIL mid_stall_reset: got %h required 0", {stall, RW_dm});
    end
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({stall, alu_op, mux_sel_A, mux_sel_B} !== {1'b0, T_ADD, 4'b0000}) begin
      n_err++;
      $display("FAIL mid_stall_after: got %h required %h", {stall, alu_op, mux_sel_A, mux_sel_B},
               {1'b0, T_ADD, 4'b0000});
    end
  endtask

  task automatic test_random();
    logic [31:0] cur;
    logic        cur_v;
    logic        held;
    logic [5:0]  op;
    logic [4:0]  rw, ra, rb;
    logic        is_alu, is_immop, use_src, e_isel, e_stall;
    logic [1:0]  e_sa, e_sb;
    logic [5:0]  e_op;
    rec_t        nr;
    held = 1'b0;
    cur = 32'd0;
    cur_v = 1'b0;
    flush();
    mq = {};
    for (int i = 0; i < 3; i++) mq.push_back(7'd0);
    for (int n = 0; n < 400; n++) begin
      if (!held) begin
        cur_v = ($urandom_range(9) != 0);
        cur = rand_ins();
      end
      ins = cur;
      ins_valid = cur_v;
      op = cur[31:26];
      rw = cur[25:21];
      ra = cur[20:16];
      rb = cur[15:11];
      is_alu = (op <= 6'd4);
      is_immop = (op == T_ADDI) || (op == T_SUBI) || (op == T_LD) || (op == T_ST);
      use_src = cur_v && (is_alu || is_immop);
      e_isel = use_src && op[5];
      e_op = use_src ? op : T_NOP;
      e_sa = model_sel(ra, use_src);
      e_sb = e_isel ? 2'd0 : model_sel(rb, use_src);
      e_stall = use_src && mq[0].v && mq[0].ld &&
                ((ra != 5'd0 && ra == mq[0].rw) || (!e_isel && rb != 5'd0 && rb == mq[0].rw));
      #2;
      n_cmp++;
      if (stall !== e_stall) begin
        n_err++;
        $display("FAIL rnd_stall[%0d]: got %b required %b ins=%h", n, stall, e_stall, cur);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (!cur_v || e_stall) begin
        if ({alu_op, imm_sel, mux_sel_A, mux_sel_B} !== {T_NOP, 1'b0, 4'b0000}) begin
          n_err++;
          $display("FAIL rnd_bubble[%0d]: got %h required %h", n,
                   {alu_op, imm_sel, mux_sel_A, mux_sel_B}, {T_NOP, 1'b0, 4'b0000});
        end
      end else begin
        if ({RA, RB, imm, imm_sel, alu_op, mux_sel_A, mux_sel_B} !==
            {ra, rb, cur[15:0], e_isel, e_op, e_sa, e_sb}) begin
          n_err++;
          $display("FAIL rnd_issue[%0d]: got %h required %h ins=%h", n,
                   {RA, RB, imm, imm_sel, alu_op, mux_sel_A, mux_sel_B},
                   {ra, rb, cur[15:0], e_isel, e_op, e_sa, e_sb}, cur);
        end
      end
      nr = 7'd0;
      if (!e_stall && use_src && op != T_ST && rw != 5'd0) begin
        nr.v = 1'b1;
        nr.rw = rw;
        nr.ld = (op == T_LD);
      end
      mq.push_front(nr);
      void'(mq.pop_back());
      n_cmp++;
      if (RW_dm !== (mq[1].v ? mq[1].rw : 5'd0)) begin
        n_err++;
        $display("FAIL rnd_rw_dm[%0d]: got %0d required %0d", n, RW_dm,
                 mq[1].v ? mq[1].rw : 5'd0);
      end
      held = e_stall;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ins = 32'd0;
    ins_valid = 1'b0;
    test_reset();
    test_back_to_back();
    test_distance();
    test_imm_r0();
    test_load_use();
    test_priority();
    test_reset_mid_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dependency_check_unit.md
Name: dependency_check_unit

Overview:
Decode-stage hazard and forwarding controller that sits directly upstream of the register bank. It accepts one 32-bit instruction per cycle and drives the register-bank control inputs: RA, RB, RW_dm, imm, mux_sel_A, mux_sel_B and imm_sel. It tracks the destination registers of the three older in-flight instructions (EX, DM, WB) to pick forwarding sources. It also raises a one-cycle stall on a load-use hazard.

Parameters:
DATA_W, 16, width of imm and datapath operands
REG_AW, 5, register address width
INS_W, 32, instruction width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
ins  in  32  instruction word; held stable by upstream while stall=1
ins_valid  in  1  ins carries a real instruction; 0 inserts a bubble
RA  out  5  source A address to register bank
RB  out  5  source B address to register bank
RW_dm  out  5  destination register of the instruction now in DM (write-back address)
imm  out  16  immediate field
imm_sel  out  1  1 = B operand is imm
mux_sel_A  out  2  A source: 00 regfile, 01 ans_ex, 10 ans_dm, 11 ans_wb
mux_sel_B  out  2  same encoding for B
alu_op  out  6  opcode passed to EX
stall  out  1  hold fetch and ins for this cycle

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. While rst_n=0, every output and history entry is 0 (stall=0, all mux_sel=00, history valid bits cleared).
- Instruction fields: opcode=ins[31:26], RW=ins[25:21], RA=ins[20:16], RB=ins[15:11], imm=ins[15:0].
- Opcodes:
  - ALU register ops: ADD 000000, SUB 000001, AND 000010, OR 000011, XOR 000100.
  - Immediate ops: ADDI 100000, SUBI 100001, LD 101100, ST 101101.
  - NOP 111111. Unlisted opcodes decode as NOP.
- imm_sel = opcode[5] for non-NOP; 0 for NOP.
- writes_reg = 1 for ALU, ADDI, SUBI and LD; 0 for ST, NOP and bubbles. Any destination equal to 0 is also treated as non-writing (R0 is constant zero).
- History: three slots hist_ex, hist_dm, hist_wb, each holding {valid, RW, is_load}.
  - Every cycle: hist_wb<=hist_dm; hist_dm<=hist_ex; hist_ex<=current decode entry.
  - On a stall cycle or when ins_valid=0, the entry shifted in is a bubble (valid=0).
- Forwarding select, per source (A uses RA, B uses RB), computed combinationally against the pre-update history, nearest match wins:
  - src==hist_ex.RW and valid → 01
  - else src==hist_dm.RW and valid → 10
  - else src==hist_wb.RW and valid → 11
  - else 00
  - Source address 0 always gives 00.
  - When imm_sel=1, mux_sel_B is forced to 00.
- Load-use hazard: hist_ex.valid & hist_ex.is_load & (RA match, or RB match with imm_sel=0), both non-zero.
  - stall=1 combinationally in that cycle.
  - A bubble enters the history. The registered outputs keep the bubble control values: mux_sel 00, imm_sel 0, alu_op NOP.
  - On the next cycle the same ins is re-decoded. The load is now in hist_dm, so it forwards with sel 10 and stall falls.
- Latency: RA, RB, imm, imm_sel, alu_op and mux_sel are registered and valid 1 cycle after ins is sampled (ID→EX boundary).
- RW_dm is the RW field of hist_dm, or 0 if that entry is invalid.
- Simultaneous matches (e.g. RA==RB, both hazards): both selects are resolved independently; a single stall covers both.
- Reset mid-stall: stall drops immediately and the history is flushed.

Decomposition:
- Shared package dcu_pkg holds:
  - the opcode constants;
  - the mux_sel encodings (SEL_RF, SEL_EX, SEL_DM, SEL_WB);
  - the hist_entry typedef {valid, rw[4:0], is_load}.
- One sub-module, fwd_select: combinational compare of one source address against the three history slots, returning a 2-bit select. It is instantiated twice, for A and for B.

Test Plan:
- Reset: rst_n=0 mid-stream → all outputs 0 asynchronously; after release, first ADD R3,R1,R2 gives mux_sel_A=00, mux_sel_B=00.
- Back-to-back forwarding: ADD R7,R1,R2 then SUB R8,R7,R7 → second instruction's mux_sel_A=01, mux_sel_B=01.
- Distance 2 and 3:
  - ADD R7; NOP; ADD R9,R7,R2 → mux_sel_A=10.
  - With two NOPs in between → mux_sel_A=11; with three → 00.
  - RW_dm=7 two cycles after ADD R7 issues.
- Immediate and R0: ADDI R5,R0,0xFFFF after ADD R0,… → imm=FFFF, imm_sel=1, mux_sel_A=00, mux_sel_B=00.
- Load-use:
  - LD R6,R1,#4 then ADD R4,R6,R2 → stall=1 for exactly one cycle and a bubble is issued.
  - The re-decoded ADD then has mux_sel_A=10.
- Priority: ADD R7; ADD R7; ADD R3,R7,R7 → selects 01, not 10, for both A and B.
